// File: rtl/median_pkg.sv
// median_pkg: shared FSM encoding and default image geometry for the median frame controller.
package median_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
    localparam int DEF_ROW = 256;
    localparam int DEF_COL = 256;
    localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/fifo_occ_tracker.sv
// fifo_occ_tracker: mirrors the datapath output FIFO occupancy and flags pushes into a full FIFO.
module fifo_occ_tracker #(
    parameter int DEPTH = 16,
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    output logic          push_ok,
    output logic [OW-1:0] occupancy,
    output logic          full,
    output logic          empty,
    output logic          overflow
);
    assign full = occupancy == OW'(DEPTH);
    assign empty = occupancy == '0;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push_ok = push && (!full || pop);
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            occupancy <= '0;
            overflow <= 1'b0;
        end else begin
            occupancy <= occupancy + OW'(push_ok && !pop) - OW'(pop && !push_ok);
            if (push && !push_ok) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: streams one frame from source memory through the median datapath
// and writes the filtered pixels to destination memory in address order.
module median_frame_ctrl
    import median_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROW = DEF_ROW,
    parameter int COL = DEF_COL,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  src_rd_en,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic [DATA_WIDTH-1:0] dp_data_in,
    input  logic                  dp_valid_out,
    output logic                  dp_push,
    output logic                  dp_pop,
    input  logic [DATA_WIDTH-1:0] dp_data_out,
    output logic                  dst_wr_en,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [DATA_WIDTH-1:0] dst_data,
    input  logic                  dst_ready
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] N = CW'(ROW * COL);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    state_t state, state_n;
    logic [CW-1:0] rd_cnt, push_cnt, wr_cnt;
    logic rd_q, pop_q, launch, push_req, full, empty;
    logic [OW-1:0] occupancy;
    assign launch = state == IDLE && start;
    assign busy = state == FEED || state == DRAIN;
    assign done = state == DONE;
    assign src_rd_en = state == FEED;
    assign src_addr = src_rd_en ? rd_cnt[ADDR_WIDTH-1:0] : '0;
    // zeros between reads act as flush padding for the filter window
    assign dp_data_in = rd_q ? src_data : '0;
    assign push_req = busy && dp_valid_out && push_cnt < N;
    assign dp_pop = busy && !empty && dst_ready;
    assign dst_wr_en = pop_q;
    assign dst_data = pop_q ? dp_data_out : '0;
    assign dst_addr = pop_q ? wr_cnt[ADDR_WIDTH-1:0] : '0;
    fifo_occ_tracker #(.DEPTH(FIFO_DEPTH)) u_occ (
        .clk(clk),
        .reset(reset),
        .clr(launch),
        .push(push_req),
        .pop(dp_pop),
        .push_ok(dp_push),
        .occupancy(occupancy),
        .full(full),
        .empty(empty),
        .overflow(overflow)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = start ? FEED : IDLE;
            FEED: state_n = (rd_cnt == N - 1'b1) ? DRAIN : FEED;
            DRAIN: state_n = (dst_wr_en && wr_cnt == N - 1'b1) ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rd_cnt <= '0;
            push_cnt <= '0;
            wr_cnt <= '0;
            rd_q <= 1'b0;
            pop_q <= 1'b0;
        end else begin
            state <= state_n;
            rd_q <= src_rd_en;
            pop_q <= dp_pop;
            if (launch) begin
                rd_cnt <= '0;
                push_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                rd_cnt <= rd_cnt + CW'(src_rd_en);
                push_cnt <= push_cnt + CW'(dp_push);
                wr_cnt <= wr_cnt + CW'(dst_wr_en);
            end
        end
    end
    occ_in_range: assert property (@(posedge clk) disable iff (reset)
        occupancy <= OW'(FIFO_DEPTH) && full == (occupancy == OW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb_median_frame_ctrl: randomized frames through a 5-cycle filter model and a 4-deep FIFO model,
// writes checked against a per-frame scoreboard of expected (address, filtered pixel) pairs.
module tb_median_frame_ctrl;
    localparam int AW = 4, DW = 8, N = 16, D = 4, LAT = 5, TMO = 200;
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
    logic clk = 0, reset = 1, start = 0, dst_ready = 1;
    logic busy, done, overflow, src_rd_en, dp_push, dp_pop, dst_wr_en, dp_valid_out;
    logic [AW-1:0] src_addr, dst_addr;
    logic [DW-1:0] src_data = '0, dp_data_in, dp_data_out = '0, dst_data;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] dpipe [LAT];
    logic [LAT-1:0] vpipe = '0;
    logic feed_q = 0;
    logic [DW-1:0] fifo [$];
    exp_t sb [$];
    int checks = 0, failures = 0, done_cnt = 0, rd_seen = 0, exp_rd = 0, peak = 0;
    bit sb_on = 0;

    always #5 clk = ~clk;

    median_frame_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW(4), .COL(4), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .overflow(overflow),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
        .dp_data_in(dp_data_in), .dp_valid_out(dp_valid_out), .dp_push(dp_push), .dp_pop(dp_pop),
        .dp_data_out(dp_data_out), .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data),
        .dst_ready(dst_ready)
    );

    function automatic logic [DW-1:0] filt(input logic [DW-1:0] x);
        return ~x + DW'(7);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // source memory: one-cycle read latency
    always @(posedge clk) src_data <= mem[src_addr];

    // filter model: input is valid the cycle after a read, output appears LAT cycles later
    always @(posedge clk) begin
        feed_q <= reset ? 1'b0 : src_rd_en;
        vpipe <= reset ? '0 : {vpipe[LAT-2:0], feed_q};
        dpipe[0] <= filt(dp_data_in);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign dp_valid_out = vpipe[LAT-1];

    // datapath output FIFO model
    always @(posedge clk) begin
        if (reset) fifo.delete();
        else begin
            if (dp_pop && fifo.size() > 0) dp_data_out <= fifo.pop_front();
            if (dp_push) fifo.push_back(dpipe[LAT-1]);
        end
    end

    // monitor
    always @(negedge clk) begin
        exp_t e;
        if (fifo.size() > peak) peak = fifo.size();
        if (busy) chk("fifo_bound", fifo.size() <= D, 1);
        if (done) done_cnt++;
        if (src_rd_en) begin
            chk("src_addr", src_addr, exp_rd[AW-1:0]);
            exp_rd++;
            rd_seen++;
        end
        if (dst_wr_en && sb_on) begin
            chk("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dst_addr", dst_addr, e.a);
                chk("dst_data", dst_data, e.d);
            end
        end
    end

    task automatic launch_frame(input bit scored);
        exp_t e;
        sb.delete();
        for (int i = 0; i < N; i++) begin
            mem[i] = DW'($urandom);
            e.a = AW'(i);
            e.d = filt(mem[i]);
            if (scored) sb.push_back(e);
        end
        sb_on = scored;
        rd_seen = 0;
        exp_rd = 0;
        done_cnt = 0;
        peak = 0;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic stall_after_first_write(input int len);
        int t = 0;
        while (!dst_wr_en && t < TMO) begin tick(); t++; end
        chk("first_write_in_time", t < TMO, 1);
        tick(2);
        dst_ready = 0;
        tick(len);
        dst_ready = 1;
    endtask

    task automatic finish_frame();
        int t = 0;
        while (done_cnt == 0 && t < TMO) begin tick(); t++; end
        tick(3);
        chk("done_pulses", done_cnt, 1);
        chk("reads", rd_seen, N);
        chk("sb_drained", sb.size(), 0);
        chk("overflow_clear", overflow, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        for (int i = 0; i < N; i++) mem[i] = '0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_en", src_rd_en, 0);
        chk("rst_wr_en", dst_wr_en, 0);
        chk("rst_push", dp_push, 0);
        chk("rst_pop", dp_pop, 0);
        chk("rst_src_addr", src_addr, 0);
        reset = 0;
        tick(2);
        chk("idle_busy", busy, 0);

        // plain frames
        repeat (2) begin
            launch_frame(1);
            chk("busy_in_feed", busy, 1);
            finish_frame();
        end

        // 3-cycle stall: FIFO fills to depth, then push+pop at full holds it there
        launch_frame(1);
        stall_after_first_write(3);
        finish_frame();
        chk("peak_occupancy", peak, D);

        // random short stall
        launch_frame(1);
        stall_after_first_write($urandom_range(1, 3));
        finish_frame();

        // start re-pulsed during FEED is ignored
        launch_frame(1);
        tick(4);
        start = 1;
        tick();
        start = 0;
        finish_frame();

        // 8-cycle stall overflows; frame then cannot complete and is reset away
        launch_frame(0);
        stall_after_first_write(8);
        t = 0;
        while (!overflow && t < 20) begin tick(); t++; end
        chk("overflow_set", overflow, 1);
        tick(5);
        chk("overflow_sticky", overflow, 1);
        chk("no_done_on_overflow", done_cnt, 0);
        reset = 1;
        tick();
        reset = 0;
        chk("overflow_reset", overflow, 0);

        // reset at src_addr=7 abandons the frame
        launch_frame(0);
        t = 0;
        while (!(src_rd_en && src_addr == AW'(7)) && t < TMO) begin tick(); t++; end
        chk("reached_addr7", t < TMO, 1);
        reset = 1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", src_rd_en, 0);
        chk("abort_push", dp_push, 0);
        chk("abort_pop", dp_pop, 0);
        chk("abort_wr_en", dst_wr_en, 0);
        chk("abort_done", done, 0);
        chk("abort_src_addr", src_addr, 0);
        chk("abort_dst_addr", dst_addr, 0);
        chk("abort_dst_data", dst_data, 0);
        reset = 0;
        tick(10);
        chk("abort_no_done", done_cnt, 0);
        launch_frame(1);
        finish_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
